// File: rtl/dsp_mac_slice_pkg.sv
// dsp_mac_pkg: shared constants for the DSP MAC slice.
// opmode bit positions, X/Z select encodings and default widths.
package dsp_mac_pkg;

   localparam int DW_DEF = 18;
   localparam int PW_DEF = 48;

   // opmode bit positions
   localparam int OP_X_LSB    = 0;
   localparam int OP_Z_LSB    = 2;
   localparam int OP_PRE_EN   = 4;
   localparam int OP_CIN_EN   = 5;
   localparam int OP_PRE_SUB  = 6;
   localparam int OP_POST_SUB = 7;

   // X operand select, opmode[1:0]
   typedef enum logic [1:0] {
      X_ZERO = 2'd0,
      X_M    = 2'd1,
      X_P    = 2'd2,
      X_DAB  = 2'd3
   } xsel_e;

   // Z operand select, opmode[3:2]
   typedef enum logic [1:0] {
      Z_ZERO = 2'd0,
      Z_PCIN = 2'd1,
      Z_P    = 2'd2,
      Z_C    = 2'd3
   } zsel_e;

endpackage

// File: rtl/dsp_mac_slice_if.sv
// dsp_mac_slice_if: operand/control/result bundle for dsp_mac_slice.
// master drives operands and controls, slave (the slice) drives results.
interface dsp_mac_slice_if
   import dsp_mac_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int PW = PW_DEF
);
   logic [DW-1:0]   A, B, D;
   logic [PW-1:0]   C, PCIN;
   logic            carryin;
   logic [7:0]      opmode;
   logic            ce, clr, in_valid;

   logic [DW-1:0]   BCOUT;
   logic [2*DW-1:0] M;
   logic [PW-1:0]   P, PCOUT;
   logic            carryout, carryoutF, sat, out_valid;

   modport master (
      output A, B, D, C, PCIN, carryin, opmode, ce, clr, in_valid,
      input  BCOUT, M, P, PCOUT, carryout, carryoutF, sat, out_valid
   );

   modport slave (
      input  A, B, D, C, PCIN, carryin, opmode, ce, clr, in_valid,
      output BCOUT, M, P, PCOUT, carryout, carryoutF, sat, out_valid
   );
endinterface

// File: rtl/dsp_mac_slice_post_adder.sv
// dsp_post_adder: combinational post-adder/subtractor with carry.
// Define DSP_MAC_SAT_EN to clamp on overflow/underflow; otherwise wrap.
module dsp_post_adder
   import dsp_mac_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic [PW-1:0] i_x,
   input  logic [PW-1:0] i_z,
   input  logic          i_cin,
   input  logic          i_sub,
   output logic [PW-1:0] o_p,
   output logic          o_co,
   output logic          o_sat
);
   logic [PW:0] w_r;
   logic [PW:0] w_xc;

   // One extra bit so carry (add) or borrow (sub) lands in w_r[PW]
   always_comb begin
      w_xc = {1'b0, i_x} + {{PW{1'b0}}, i_cin};
      w_r  = i_sub ? ({1'b0, i_z} - w_xc) : ({1'b0, i_z} + w_xc);
   end

   assign o_co = w_r[PW];

`ifdef DSP_MAC_SAT_EN
   // Clamp: add overflow pins to all ones, subtract underflow pins to zero
   always_comb begin
      o_sat = w_r[PW];
      o_p   = w_r[PW-1:0];
      if (w_r[PW])
         o_p = i_sub ? '0 : '1;
   end
`else
   assign o_p   = w_r[PW-1:0];
   assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: 3-stage pre-add / multiply / post-add DSP slice.
// Optional saturation of the post-adder via macro DSP_MAC_SAT_EN.
module dsp_mac_slice
   import dsp_mac_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int PW = PW_DEF
) (
   input logic             clk,
   input logic             rst,
   dsp_mac_slice_if.slave  bus
);
   if (PW < 2*DW) begin : g_pw_chk
      $error("dsp_mac_slice: PW must be at least 2*DW");
   end

   // stage 1
   logic [DW-1:0]   r1_a, r1_b, r1_d;
   logic [PW-1:0]   r1_c, r1_pcin;
   logic            r1_cin;
   logic [7:0]      r1_op;
   // stage 2
   logic [DW-1:0]   r_bcout, r2_a, r2_b, r2_d;
   logic [2*DW-1:0] r_m;
   logic [PW-1:0]   r2_c, r2_pcin;
   logic            r2_cin;
   logic [7:0]      r2_op;
   // stage 3
   logic [PW-1:0]   r_p;
   logic            r_co, r_sat;
   logic [3:1]      r_vld_pipe;

   logic [DW-1:0]   w_bcout;
   logic [2*DW-1:0] w_m;
   logic [PW-1:0]   w_x, w_z, w_p;
   logic            w_co, w_sat;

   // Stage 1: capture operands and controls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_a <= '0; r1_b <= '0; r1_d <= '0;
         r1_c <= '0; r1_pcin <= '0; r1_cin <= 1'b0; r1_op <= '0;
      end else if (bus.ce) begin
         r1_a <= bus.A; r1_b <= bus.B; r1_d <= bus.D;
         r1_c <= bus.C; r1_pcin <= bus.PCIN; r1_cin <= bus.carryin;
         r1_op <= bus.opmode;
      end
   end

   // Pre-adder (wraps mod 2^DW) feeding the multiplier
   always_comb begin
      w_bcout = r1_b;
      if (r1_op[OP_PRE_EN])
         w_bcout = r1_op[OP_PRE_SUB] ? (r1_d - r1_b) : (r1_d + r1_b);
      w_m = {{DW{1'b0}}, w_bcout} * {{DW{1'b0}}, r1_a};
   end

   // Stage 2: register pre-adder/product, carry stage-1 fields forward
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcout <= '0; r_m <= '0;
         r2_a <= '0; r2_b <= '0; r2_d <= '0;
         r2_c <= '0; r2_pcin <= '0; r2_cin <= 1'b0; r2_op <= '0;
      end else if (bus.ce) begin
         r_bcout <= w_bcout; r_m <= w_m;
         r2_a <= r1_a; r2_b <= r1_b; r2_d <= r1_d;
         r2_c <= r1_c; r2_pcin <= r1_pcin; r2_cin <= r1_cin; r2_op <= r1_op;
      end
   end

   // X/Z muxes driven by the opmode copy that reaches stage 3
   always_comb begin
      w_x = '0;
      w_z = '0;
      case (xsel_e'(r2_op[OP_X_LSB +: 2]))
         X_M:     w_x = PW'(r_m);
         X_P:     w_x = r_p;
         X_DAB:   w_x = PW'({r2_d, r2_a, r2_b});
         default: w_x = '0;
      endcase
      case (zsel_e'(r2_op[OP_Z_LSB +: 2]))
         Z_PCIN:  w_z = r2_pcin;
         Z_P:     w_z = r_p;
         Z_C:     w_z = r2_c;
         default: w_z = '0;
      endcase
   end

   dsp_post_adder #(.PW(PW)) u_post (
      .i_x   (w_x),
      .i_z   (w_z),
      .i_cin (r2_cin & r2_op[OP_CIN_EN]),
      .i_sub (r2_op[OP_POST_SUB]),
      .o_p   (w_p),
      .o_co  (w_co),
      .o_sat (w_sat)
   );

   // Stage 3: result register; clr wins over ce
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p <= '0; r_co <= 1'b0; r_sat <= 1'b0;
      end else if (bus.clr) begin
         r_p <= '0; r_co <= 1'b0; r_sat <= 1'b0;
      end else if (bus.ce) begin
         r_p <= w_p; r_co <= w_co; r_sat <= w_sat;
      end
   end

   // Valid shift register, advances only on ce
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_vld_pipe <= '0;
      else if (bus.ce)
         r_vld_pipe <= {r_vld_pipe[2:1], bus.in_valid};
   end

   assign bus.BCOUT     = r_bcout;
   assign bus.M         = r_m;
   assign bus.P         = r_p;
   assign bus.PCOUT     = r_p;
   assign bus.carryout  = r_co;
   assign bus.carryoutF = r_co;
   assign bus.sat       = r_sat;
   assign bus.out_valid = r_vld_pipe[3];

endmodule
